// File: rtl/instr_sequencer_if.sv
// Instruction sequencer bus.
// Carries the start/instruction handshake into the sequencer and every
// register-file and datapath control it produces.
//   master : the issuing side; drives s/in, observes w and the controls
//   slave  : the sequencer; samples s/in, drives everything else
interface instr_sequencer_if;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  modport master (
    output s, in,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads,
    input  asel, bsel, vsel, shift, ALUop, sximm8, sximm5
  );

  modport slave (
    input  s, in,
    output w, readnum, writenum, write, loada, loadb, loadc, loads,
    output asel, bsel, vsel, shift, ALUop, sximm8, sximm5
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: control FSM ahead of the register file and datapath.
// Latches one 16-bit instruction per accepted start pulse, decodes it and
// walks through operand reads, ALU evaluation and write-back.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset (back to WAIT, IR cleared)
//   bus      : slave side of instr_sequencer_if
//              in : s (start, sampled only in WAIT), in (instruction)
//              out: w (idle), readnum/writenum/write (regfile),
//                   loada/loadb/loadc/loads (datapath register enables),
//                   asel/bsel/vsel/shift/ALUop (datapath selects),
//                   sximm8/sximm5 (sign-extended IR immediates)
module instr_sequencer (
  input logic               clk,
  input logic               reset_n,
  instr_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_DECODE,
    ST_WRITE_IMM,
    ST_GET_A,
    ST_GET_B,
    ST_ALU,
    ST_WRITE_REG
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;

  // IR fields
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  // Instruction classes
  logic is_mov_imm;
  logic is_mov_reg;
  logic is_two_op;   // ADD, CMP, AND: read Rn and Rm
  logic is_mvn;
  logic is_cmp;

  // Registered-output-free Moore controls
  logic       w_o;
  logic [2:0] readnum_o;
  logic [2:0] writenum_o;
  logic       write_o;
  logic       loada_o;
  logic       loadb_o;
  logic       loadc_o;
  logic       loads_o;
  logic       asel_o;
  logic       bsel_o;
  logic [1:0] vsel_o;
  logic [1:0] shift_o;
  logic [1:0] aluop_o;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_two_op  = (opcode == 3'b101) && (op != 2'b11);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);

  // State and instruction register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_WAIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_WAIT) && bus.s) begin
        ir <= bus.in;
      end
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_nxt  = state;
    w_o        = 1'b0;
    readnum_o  = '0;
    writenum_o = '0;
    write_o    = 1'b0;
    loada_o    = 1'b0;
    loadb_o    = 1'b0;
    loadc_o    = 1'b0;
    loads_o    = 1'b0;
    asel_o     = 1'b0;
    bsel_o     = 1'b0;
    vsel_o     = '0;
    shift_o    = '0;
    aluop_o    = '0;

    unique case (state)
      ST_WAIT: begin
        w_o = 1'b1;
        if (bus.s) begin
          state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (is_mov_imm) begin
          state_nxt = ST_WRITE_IMM;
        end else if (is_two_op) begin
          state_nxt = ST_GET_A;
        end else if (is_mov_reg || is_mvn) begin
          state_nxt = ST_GET_B;
        end else begin
          state_nxt = ST_WAIT;
        end
      end

      ST_WRITE_IMM: begin
        write_o    = 1'b1;
        writenum_o = rn;
        vsel_o     = 2'b10;
        state_nxt  = ST_WAIT;
      end

      ST_GET_A: begin
        readnum_o = rn;
        loada_o   = 1'b1;
        state_nxt = ST_GET_B;
      end

      ST_GET_B: begin
        readnum_o = rm;
        loadb_o   = 1'b1;
        state_nxt = ST_ALU;
      end

      ST_ALU: begin
        shift_o = sh;
        bsel_o  = 1'b0;
        // Single-operand forms zero the A side so the ALU passes B
        // (MOV as B+0, MVN as ~B).
        if (is_two_op) begin
          aluop_o = op;
          asel_o  = 1'b0;
        end else if (is_mvn) begin
          aluop_o = 2'b11;
          asel_o  = 1'b1;
        end else begin
          aluop_o = 2'b00;
          asel_o  = 1'b1;
        end
        // CMP only updates status; everything else produces a result.
        if (is_cmp) begin
          loads_o   = 1'b1;
          state_nxt = ST_WAIT;
        end else begin
          loadc_o   = 1'b1;
          state_nxt = ST_WRITE_REG;
        end
      end

      ST_WRITE_REG: begin
        write_o    = 1'b1;
        writenum_o = rd;
        vsel_o     = 2'b00;
        state_nxt  = ST_WAIT;
      end

      default: begin
        state_nxt = ST_WAIT;
      end
    endcase
  end

  assign bus.w        = w_o;
  assign bus.readnum  = readnum_o;
  assign bus.writenum = writenum_o;
  assign bus.write    = write_o;
  assign bus.loada    = loada_o;
  assign bus.loadb    = loadb_o;
  assign bus.loadc    = loadc_o;
  assign bus.loads    = loads_o;
  assign bus.asel     = asel_o;
  assign bus.bsel     = bsel_o;
  assign bus.vsel     = vsel_o;
  assign bus.shift    = shift_o;
  assign bus.ALUop    = aluop_o;

  // Immediates follow IR in every state.
  assign bus.sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign bus.sximm5 = {{11{ir[4]}}, ir[4:0]};

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed test-plan instructions,
// mid-instruction resets and a randomized instruction stream, each cycle
// compared against a per-instruction step list built from the ISA rules.
module tb_instr_sequencer;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctrl_t;

  logic clk;
  logic reset_n;
  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_err;
  logic [15:0] ir_model;
  ctrl_t       exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sext(input int v, input int bits);
    int half;
    int r;
    half = 1 << (bits - 1);
    r = (v >= half) ? v - 2 * half : v;
    return 16'(r);
  endfunction

  function automatic ctrl_t observed();
    ctrl_t o;
    o.w        = bus.w;
    o.readnum  = bus.readnum;
    o.writenum = bus.writenum;
    o.write    = bus.write;
    o.loada    = bus.loada;
    o.loadb    = bus.loadb;
    o.loadc    = bus.loadc;
    o.loads    = bus.loads;
    o.asel     = bus.asel;
    o.bsel     = bus.bsel;
    o.vsel     = bus.vsel;
    o.shift    = bus.shift;
    o.aluop    = bus.ALUop;
    return o;
  endfunction

  function automatic ctrl_t idle_ctrl();
    ctrl_t c;
    c   = '0;
    c.w = 1'b1;
    return c;
  endfunction

  // Reference: the list of busy-cycle control words an instruction produces.
  function automatic void build_model(input logic [15:0] instr);
    ctrl_t c;
    int    opc;
    int    op;
    bit    mov_imm, mov_reg, mvn, cmp, two_op;
    opc     = int'(instr[15:13]);
    op      = int'(instr[12:11]);
    mov_imm = (opc == 6) && (op == 2);
    mov_reg = (opc == 6) && (op == 0);
    two_op  = (opc == 5) && (op <= 2);
    mvn     = (opc == 5) && (op == 3);
    cmp     = (opc == 5) && (op == 1);
    exp_q.delete();
    c = '0;
    exp_q.push_back(c);                       // decode
    if (mov_imm) begin
      c = '0; c.write = 1'b1; c.writenum = instr[10:8]; c.vsel = 2'b10;
      exp_q.push_back(c);
    end else if (two_op || mov_reg || mvn) begin
      if (two_op) begin
        c = '0; c.readnum = instr[10:8]; c.loada = 1'b1;
        exp_q.push_back(c);
      end
      c = '0; c.readnum = instr[2:0]; c.loadb = 1'b1;
      exp_q.push_back(c);
      c = '0;
      c.shift = instr[4:3];
      c.aluop = two_op ? 2'(op) : (mvn ? 2'b11 : 2'b00);
      c.asel  = !two_op;
      if (cmp) c.loads = 1'b1;
      else     c.loadc = 1'b1;
      exp_q.push_back(c);
      if (!cmp) begin
        c = '0; c.write = 1'b1; c.writenum = instr[7:5];
        exp_q.push_back(c);
      end
    end
  endfunction

  task automatic check_cycle(input string tag, input ctrl_t e);
    check_eq({tag, ".ctrl"}, {12'b0, observed()}, {12'b0, e});
    check_eq({tag, ".sximm8"}, {16'b0, bus.sximm8},
             {16'b0, sext(int'(ir_model[7:0]), 8)});
    check_eq({tag, ".sximm5"}, {16'b0, bus.sximm5},
             {16'b0, sext(int'(ir_model[4:0]), 5)});
  endtask

  // Called #1 after an edge while in WAIT; returns #1 after the edge that
  // lands back in WAIT, with s low.
  task automatic run_instr(input string tag, input logic [15:0] instr);
    int unsigned busy;
    build_model(instr);
    bus.s  = 1'b1;
    bus.in = instr;
    @(posedge clk); #1;
    ir_model = instr;
    busy = 0;
    foreach (exp_q[i]) begin
      check_cycle($sformatf("%s.busy%0d", tag, i), exp_q[i]);
      busy += (bus.w == 1'b0) ? 1 : 0;
      bus.s  = 1'($urandom_range(0, 1));
      bus.in = 16'($urandom);
      @(posedge clk); #1;
    end
    bus.s = 1'b0;
    check_eq({tag, ".busy_len"}, busy, exp_q.size());
    check_cycle({tag, ".wait"}, idle_ctrl());
  endtask

  task automatic idle(input int unsigned n);
    bus.s = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check_cycle("idle", idle_ctrl());
    end
  endtask

  // Accept instr, advance to busy cycle 'at' (1 = decode), then pull reset.
  task automatic reset_at(input string tag, input logic [15:0] instr,
                          input int unsigned at);
    bus.s  = 1'b1;
    bus.in = instr;
    @(posedge clk); #1;
    bus.s = 1'b0;
    for (int unsigned k = 1; k < at; k++) begin
      @(posedge clk); #1;
    end
    #2 reset_n = 1'b0;
    #1;
    ir_model = '0;
    check_cycle({tag, ".abort"}, idle_ctrl());
    @(posedge clk); #1;
    check_cycle({tag, ".held"}, idle_ctrl());
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_cycle({tag, ".release"}, idle_ctrl());
  endtask

  initial begin
    logic [15:0] instr;
    int unsigned cls;
    n_cmp    = 0;
    n_err    = 0;
    ir_model = '0;
    reset_n  = 1'b0;
    bus.s    = 1'b0;
    bus.in   = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    check_cycle("reset", idle_ctrl());
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_cycle("post_reset", idle_ctrl());

    run_instr("mov_r3_42", 16'hD32A);
    check_eq("mov_r3_42.sximm8_abs", {16'b0, bus.sximm8}, 32'h0000_002A);
    run_instr("mov_r0_m1", 16'hD0FF);
    check_eq("mov_r0_m1.sximm8_abs", {16'b0, bus.sximm8}, 32'h0000_FFFF);
    run_instr("add_lsl", 16'hA148);
    run_instr("cmp", 16'hA900);
    run_instr("unsupported", 16'h0000);
    idle(3);
    run_instr("and", 16'hB2E5);
    run_instr("mvn", 16'hB8F1);
    run_instr("mov_reg", 16'hC0BA);

    reset_at("rst_add_getb", 16'hA148, 3);
    run_instr("mov_after_rst", 16'hD32A);
    reset_at("rst_movi_wr", 16'hD5F3, 2);
    run_instr("mov_after_rst2", 16'hD32A);

    for (int unsigned n = 0; n < 80; n++) begin
      instr = 16'($urandom);
      cls   = $urandom_range(0, 6);
      case (cls)
        0: instr[15:11] = 5'b110_10;
        1: instr[15:11] = 5'b110_00;
        2: instr[15:11] = 5'b101_00;
        3: instr[15:11] = 5'b101_01;
        4: instr[15:11] = 5'b101_10;
        5: instr[15:11] = 5'b101_11;
        default: ;
      endcase
      run_instr($sformatf("rnd%0d", n), instr);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
